// File: rtl/pipeline_result_buffer.sv
// ---------------------------------------------------------------------------
// PipelineResultBuffer
// Small in-order FIFO that sits after a stallable adder. It captures
// {carry, sum} results, exposes them to a downstream consumer through a
// valid/ready handshake, and back-pressures the adder with allow_out.
// allow_out depends only on registered occupancy and rst, never on ready_in,
// so a full buffer refuses a push even in a cycle where it also pops.
// Optional feature: define RESULT_COUNTER_EN to count pops on result_cnt;
// without it result_cnt is tied to zero.
// ---------------------------------------------------------------------------
module pipeline_result_buffer #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_in,
   input  logic                     c_in,
   input  logic [WIDTH-1:0]         sum_in,
   output logic                     allow_out,
   output logic                     valid_out,
   input  logic                     ready_in,
   output logic [WIDTH:0]           data_out,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow_err,
   output logic [15:0]              result_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] C_FULL   = CW'(DEPTH);
   localparam logic [CW-1:0] C_ONE    = CW'(1);
   localparam logic [PW-1:0] C_PTRONE = PW'(1);

   logic [WIDTH:0]  r_mem [DEPTH];
   logic [PW-1:0]   r_wrPtr;
   logic [PW-1:0]   r_rdPtr;
   logic [CW-1:0]   r_count;
   logic            r_overflow;

   logic            w_push;
   logic            w_pop;
   logic            w_overflowAttempt;

   // Handshake decode; rst forces both sides idle so nothing moves in reset
   assign allow_out         = !rst && (r_count < C_FULL);
   assign valid_out         = !rst && (r_count != '0);
   assign w_push            = valid_in && allow_out;
   assign w_pop             = valid_out && ready_in;
   assign w_overflowAttempt = !rst && valid_in && !allow_out;

   assign data_out     = valid_out ? r_mem[r_rdPtr] : '0;
   assign count        = r_count;
   assign overflow_err = r_overflow;

   // Storage array; contents need no reset because occupancy gates visibility
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= {c_in, sum_in};
      end
   end

   // Pointers, occupancy and sticky overflow flag
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrPtr    <= '0;
         r_rdPtr    <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + C_PTRONE;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + C_PTRONE;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + C_ONE;
            2'b01:   r_count <= r_count - C_ONE;
            default: r_count <= r_count;
         endcase
         if (w_overflowAttempt) begin
            r_overflow <= 1'b1;
         end
      end
   end

`ifdef RESULT_COUNTER_EN
   logic [15:0] r_resultCnt;

   // Free-running pop counter, wraps naturally at 16 bits
   always_ff @(posedge clk) begin
      if (rst) begin
         r_resultCnt <= '0;
      end else if (w_pop) begin
         r_resultCnt <= r_resultCnt + 16'd1;
      end
   end

   assign result_cnt = r_resultCnt;
`else
   assign result_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_result_buffer.sv
// ---------------------------------------------------------------------------
// tb_pipeline_result_buffer
// Table-driven directed vectors, hand-written multi-cycle sequences and a
// randomized run, all compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_pipeline_result_buffer;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   logic              clk;
   logic              rst;
   logic              valid_in;
   logic              c_in;
   logic [WIDTH-1:0]  sum_in;
   logic              allow_out;
   logic              valid_out;
   logic              ready_in;
   logic [WIDTH:0]    data_out;
   logic [$clog2(DEPTH):0] count;
   logic              overflow_err;
   logic [15:0]       result_cnt;

   int checks = 0;
   int errors = 0;

   // Reference model state: an ordered queue of stored entries
   logic [WIDTH:0] mQ[$];
   bit             mOvf;
   int             mPops;

   typedef struct {
      logic           rst;
      logic           vin;
      logic           cin;
      logic [31:0]    sum;
      logic           rdy;
      int             expCount;
      logic           expValid;
      logic           expAllow;
      logic [32:0]    expData;
      logic           expOvf;
   } vec_t;

   vec_t tbl[$];

   pipeline_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst          (rst),
      .valid_in     (valid_in),
      .c_in         (c_in),
      .sum_in       (sum_in),
      .allow_out    (allow_out),
      .valid_out    (valid_out),
      .ready_in     (ready_in),
      .data_out     (data_out),
      .count        (count),
      .overflow_err (overflow_err),
      .result_cnt   (result_cnt)
   );

   // 10 time-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Advance the model by one edge using the inputs currently applied
   task automatic modelStep();
      bit mAllow;
      bit mValid;
      mAllow = !rst && (mQ.size() < DEPTH);
      mValid = !rst && (mQ.size() != 0);
      if (rst) begin
         mQ.delete();
         mOvf  = 0;
         mPops = 0;
      end else begin
         if (valid_in && !mAllow) mOvf = 1;
         if (mValid && ready_in) begin
            void'(mQ.pop_front());
            mPops = (mPops + 1) % 65536;
         end
         if (valid_in && mAllow) mQ.push_back({c_in, sum_in});
      end
   endtask

   task automatic applyStimulus(input logic r, input logic v, input logic c,
                                input logic [WIDTH-1:0] s, input logic rd);
      rst      = r;
      valid_in = v;
      c_in     = c;
      sum_in   = s;
      ready_in = rd;
      modelStep();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag);
      logic           eValid;
      logic           eAllow;
      logic [WIDTH:0] eData;
      int             eCnt;
      eValid = !rst && (mQ.size() != 0);
      eAllow = !rst && (mQ.size() < DEPTH);
      eData  = eValid ? mQ[0] : '0;
`ifdef RESULT_COUNTER_EN
      eCnt = mPops;
`else
      eCnt = 0;
`endif
      check({tag, ".count"},  64'(count),        64'(mQ.size()));
      check({tag, ".valid"},  64'(valid_out),    64'(eValid));
      check({tag, ".allow"},  64'(allow_out),    64'(eAllow));
      check({tag, ".data"},   64'(data_out),     64'(eData));
      check({tag, ".ovf"},    64'(overflow_err), 64'(mOvf));
      check({tag, ".rescnt"}, 64'(result_cnt),   64'(eCnt));
   endtask

   initial begin
      rst = 1'b1; valid_in = 1'b0; c_in = 1'b0; sum_in = '0; ready_in = 1'b0;
      mOvf = 0; mPops = 0;

      // Directed vectors: rst, vin, cin, sum, rdy -> count, valid, allow, data, ovf
      tbl.push_back('{1'b1, 1'b0, 1'b0, 32'd0,  1'b0, 0, 1'b0, 1'b0, 33'd0, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 32'd0,  1'b0, 0, 1'b0, 1'b1, 33'd0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 1'b0, 32'd31, 1'b1, 1, 1'b1, 1'b1, 33'd31, 1'b0});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 0, 1'b0, 1'b1, 33'd0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 1'b0, 32'd1,  1'b0, 1, 1'b1, 1'b1, 33'd1, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 1'b0, 32'd2,  1'b0, 2, 1'b1, 1'b1, 33'd1, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 1'b0, 32'd3,  1'b0, 3, 1'b1, 1'b1, 33'd1, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 1'b0, 32'd4,  1'b0, 4, 1'b1, 1'b0, 33'd1, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 1'b0, 32'd5,  1'b0, 4, 1'b1, 1'b0, 33'd1, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 3, 1'b1, 1'b1, 33'd2, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 2, 1'b1, 1'b1, 33'd3, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 1, 1'b1, 1'b1, 33'd4, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 0, 1'b0, 1'b1, 33'd0, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 1'b0, 32'd10, 1'b0, 1, 1'b1, 1'b1, 33'd10, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 1'b0, 32'd11, 1'b0, 2, 1'b1, 1'b1, 33'd10, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 1'b0, 32'd12, 1'b0, 3, 1'b1, 1'b1, 33'd10, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 1'b1, 32'd13, 1'b0, 4, 1'b1, 1'b0, 33'd10, 1'b1});
      tbl.push_back('{1'b0, 1'b1, 1'b0, 32'd99, 1'b1, 3, 1'b1, 1'b1, 33'd11, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 2, 1'b1, 1'b1, 33'd12, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 1, 1'b1, 1'b1, 33'h1_0000_000D, 1'b1});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 32'd0,  1'b1, 0, 1'b0, 1'b1, 33'd0, 1'b1});

      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i].rst, tbl[i].vin, tbl[i].cin, tbl[i].sum, tbl[i].rdy);
         check($sformatf("vec%0d.count", i), 64'(count),        64'(tbl[i].expCount));
         check($sformatf("vec%0d.valid", i), 64'(valid_out),    64'(tbl[i].expValid));
         check($sformatf("vec%0d.allow", i), 64'(allow_out),    64'(tbl[i].expAllow));
         check($sformatf("vec%0d.data", i),  64'(data_out),     64'(tbl[i].expData));
         check($sformatf("vec%0d.ovf", i),   64'(overflow_err), 64'(tbl[i].expOvf));
         checkOutput($sformatf("vec%0d.model", i));
      end

      // Simultaneous push and pop at count=2 across a pointer wrap
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd100, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd101, 1'b0);
      check("pp.start.count", 64'(count), 64'd2);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, WIDTH'(102 + i), 1'b1);
         check($sformatf("pp%0d.count", i), 64'(count), 64'd2);
         check($sformatf("pp%0d.data", i), 64'(data_out), 64'(101 + i));
         checkOutput($sformatf("pp%0d.model", i));
      end

      // Reset in the middle of operation with overflow set
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      for (int i = 1; i <= 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, WIDTH'(i), 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
      check("mid.count", 64'(count), 64'd3);
      check("mid.ovf", 64'(overflow_err), 64'd1);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd77, 1'b1);
      check("inrst.count", 64'(count), 64'd0);
      check("inrst.valid", 64'(valid_out), 64'd0);
      check("inrst.allow", 64'(allow_out), 64'd0);
      check("inrst.data", 64'(data_out), 64'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
      check("postrst.count", 64'(count), 64'd0);
      check("postrst.valid", 64'(valid_out), 64'd0);
      check("postrst.ovf", 64'(overflow_err), 64'd0);
      check("postrst.allow", 64'(allow_out), 64'd1);

      // Pop counter: five push/pop pairs
      applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, WIDTH'(200 + i), 1'b0);
         applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
      end
`ifdef RESULT_COUNTER_EN
      check("rescnt.five", 64'(result_cnt), 64'd5);
`else
      check("rescnt.tied", 64'(result_cnt), 64'd0);
`endif
      checkOutput("rescnt.model");

      // Randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                       1'($urandom), WIDTH'($urandom), ($urandom_range(0, 2) != 0));
         checkOutput($sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_result_buffer.md
PIPELINE_RESULT_BUFFER -- requirements
Module: pipeline_result_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: sum width; matches the upstream stallable adder.
REQ-002 SHALL have parameter DEPTH, default 4: entry count; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port valid_in, input, 1: upstream result valid; driven by the adder's vaild_out.
REQ-006 SHALL have port c_in, input, 1: upstream carry; driven by the adder's c_out.
REQ-007 SHALL have port sum_in, input, WIDTH: upstream sum; driven by the adder's sum_out.
REQ-008 SHALL have port allow_out, output, 1: space available; drives the adder's out_allow.
REQ-009 SHALL have port valid_out, output, 1: head entry valid toward the consumer.
REQ-010 SHALL have port ready_in, input, 1: consumer accepts the head entry.
REQ-011 SHALL have port data_out, output, WIDTH+1: head entry, {carry, sum}.
REQ-012 SHALL have port count, output, $clog2(DEPTH)+1: current occupancy.
REQ-013 SHALL have port overflow_err, output, 1: sticky flag, set on a push attempt while full.
REQ-014 SHALL have port result_cnt, output, 16: number of pops; see Configuration.

Function
REQ-015 SHALL perform a push on a clk edge when valid_in=1 and allow_out=1, writing {c_in, sum_in} at the write pointer.
REQ-016 SHALL perform a pop on a clk edge when valid_out=1 and ready_in=1, advancing the read pointer.
REQ-017 SHALL drive allow_out = (count < DEPTH), decoded from registered state only, with no combinational path from ready_in.
REQ-018 SHALL, as a consequence, refuse a push when full even if a pop occurs in the same cycle; the freed slot becomes usable the next cycle.
REQ-019 SHALL drive valid_out = (count != 0), and drive data_out = entry at the read pointer when valid_out=1, else all zeros.
REQ-020 SHALL give a latency of one edge: an entry pushed at edge N appears on data_out with valid_out=1 after edge N.
REQ-021 SHALL, on simultaneous push and pop with 0 < count < DEPTH, leave count unchanged and advance both pointers.
REQ-022 SHALL, when pushing into an empty buffer, not pop in that cycle, because valid_out was 0.
REQ-023 SHALL keep data_out and valid_out stable while valid_out=1 and ready_in=0.
REQ-024 SHALL wrap both pointers modulo DEPTH, with no gap or duplicate entry at the wrap.
REQ-025 SHALL preserve push order: entries leave in exactly the order they were pushed.
REQ-026 SHALL, on valid_in=1 with allow_out=0, discard the data, set overflow_err to 1 and keep it at 1 until reset.
REQ-027 SHALL keep count within 0..DEPTH at all times.

Reset
REQ-028 SHALL, on any edge with rst=1, set both pointers to 0, count=0, overflow_err=0 and result_cnt=0.
REQ-029 SHALL hold allow_out=0, valid_out=0 and data_out=0 while rst=1.
REQ-030 SHALL, on a reset during operation, discard all stored entries and ignore push and pop in that cycle.
REQ-031 SHALL, on the first edge after rst falls, present allow_out=1 with the buffer empty.

Configuration
REQ-032 SHALL, with macro RESULT_COUNTER_EN defined, increment result_cnt by 1 on every pop, wrapping from 16'hFFFF to 0.
REQ-033 SHALL, without RESULT_COUNTER_EN, still provide the result_cnt port but tie it to 0, with no counter logic inferred.

Verification
REQ-034 Bench SHALL cover basic flow: valid_in=1, c_in=0, sum_in=31, ready_in=1 -> after one edge valid_out=1, data_out={0,31}; the next edge pops it, so count returns to 0 with no further pushes.
REQ-035 Bench SHALL cover fill and stall: ready_in=0, push sums 1,2,3,4 -> count=4, allow_out=0; a fifth valid_in=1 -> overflow_err=1 and count stays 4.
REQ-036 Bench SHALL cover drain order: from the full state, set ready_in=1 -> data_out shows 1,2,3,4 on consecutive cycles, then valid_out=0 and allow_out=1.
REQ-037 Bench SHALL cover simultaneous push and pop: with count=2, push and pop for 6 cycles crossing a pointer wrap -> count stays 2 and the output sequence is in order with no loss.
REQ-038 Bench SHALL cover reset mid-operation: count=3 and overflow_err=1, assert rst one cycle -> count=0, valid_out=0, overflow_err=0, allow_out=1 after rst falls.
REQ-039 Bench SHALL cover the counter, with RESULT_COUNTER_EN defined: 5 pops -> result_cnt=5; without the macro the same stimulus -> result_cnt=0.
